// File: rtl/ptp_ts_collector.sv
// Round-robin collector of N PTP timestamp channels into one channel-tagged FIFO with a word register bus.
// Optional 32-bit saturating clear-on-read drop counter at 0x18 when PTP_TS_COLLECTOR_DROP_CNT_EN is defined.
module ptp_ts_collector #(
  parameter int NUM_CH          = 4,
  parameter int DEPTH_LOG2      = 4,
  parameter int ADDR_IS_IN_WORD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_in,
  input  logic                 rd_in,
  input  logic [7:0]           addr_in,
  input  logic [31:0]          data_in,
  output logic [31:0]          data_out,
  input  logic [NUM_CH-1:0]    ts_valid,
  output logic [NUM_CH-1:0]    ts_ready,
  input  logic [NUM_CH*80-1:0] ts_data,
  input  logic [NUM_CH*4-1:0]  ts_msgid,
  output logic                 irq_out
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [5:0] W_CTRL = 6'd0, W_STAT = 6'd1, W_NS = 6'd2, W_SLO = 6'd3,
                         W_SHI = 6'd4, W_POP = 6'd5, W_DROP = 6'd6;

  logic [5:0]  word;
  logic [15:0] en_q;
  logic        irq_en_q;
  logic [15:0] ovf_q;
  logic        flush, pop_req, stat_w1c;

  assign word     = (ADDR_IS_IN_WORD != 0) ? addr_in[5:0] : addr_in[7:2];
  assign flush    = wr_in && (word == W_CTRL) && data_in[31];
  assign pop_req  = wr_in && (word == W_POP);
  assign stat_w1c = wr_in && (word == W_STAT);

  // Round-robin arbiter: first requester at or after rr_ptr, cyclically.
  logic [15:0] req;
  logic [3:0]  rr_ptr, gnt_ch, nxt_ptr;
  logic        gnt_vld;
  logic [4:0]  idx;

  assign req = 16'(ts_valid & en_q[NUM_CH-1:0]);

  always_comb begin
    gnt_vld = 1'b0;
    gnt_ch  = '0;
    idx     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = 5'(rr_ptr) + 5'(i);
      if (idx >= 5'(NUM_CH)) idx = idx - 5'(NUM_CH);
      if (!gnt_vld && req[idx[3:0]]) begin
        gnt_vld = 1'b1;
        gnt_ch  = idx[3:0];
      end
    end
  end

  assign nxt_ptr = (gnt_ch == 4'(NUM_CH - 1)) ? 4'd0 : gnt_ch + 4'd1;

  logic [79:0] gnt_dat;
  logic [3:0]  gnt_msg;

  always_comb begin
    ts_ready = '0;
    gnt_dat  = '0;
    gnt_msg  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (gnt_ch == 4'(c)) begin
        ts_ready[c] = gnt_vld && !rst;
        gnt_dat     = ts_data[80*c +: 80];
        gnt_msg     = ts_msgid[4*c +: 4];
      end
    end
  end

  // Shared FIFO; record = {ch, msgid, sec[47:0], ns[31:0]}.
  logic [87:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr, rptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  empty, full, pop, push, drop;
  logic [87:0]           head;
  logic [15:0]           drop_oh;

  assign empty   = (count == '0);
  assign full    = (count == (DEPTH_LOG2+1)'(DEPTH));
  assign pop     = pop_req && !empty && !flush;
  assign push    = gnt_vld && (!full || pop) && !flush;
  assign drop    = gnt_vld && full && !pop && !flush;
  assign drop_oh = drop ? (16'd1 << gnt_ch) : 16'd0;
  assign head    = empty ? 88'd0 : mem[rptr];

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= {gnt_ch, gnt_msg, gnt_dat};
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q     <= '0;
      irq_en_q <= 1'b0;
      ovf_q    <= '0;
      rr_ptr   <= '0;
    end else begin
      if (wr_in && (word == W_CTRL)) begin
        en_q     <= data_in[15:0];
        irq_en_q <= data_in[16];
      end
      if (gnt_vld) rr_ptr <= nxt_ptr;
      // A new overflow in the same cycle as its W1C wins.
      ovf_q <= (stat_w1c ? (ovf_q & ~data_in[31:16]) : ovf_q) | drop_oh;
    end
  end

  logic [31:0] drop_rdata;

`ifdef PTP_TS_COLLECTOR_DROP_CNT_EN
  logic [31:0] drop_cnt;
  logic        drop_rd;

  assign drop_rd    = rd_in && (word == W_DROP);
  assign drop_rdata = drop_cnt;

  always_ff @(posedge clk) begin
    if (rst || flush)                  drop_cnt <= '0;
    else if (drop_rd)                  drop_cnt <= drop ? 32'd1 : 32'd0;
    else if (drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + 32'd1;
  end
`else
  assign drop_rdata = '0;
`endif

  logic [31:0] rdata;

  always_comb begin
    rdata = '0;
    case (word)
      W_CTRL:  rdata = {15'd0, irq_en_q, en_q};
      W_STAT:  rdata = {ovf_q, 5'd0, full, empty, 9'(count)};
      W_NS:    rdata = head[31:0];
      W_SLO:   rdata = head[63:32];
      W_SHI:   rdata = {8'd0, head[87:84], head[83:80], head[79:64]};
      W_DROP:  rdata = drop_rdata;
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)        data_out <= '0;
    else if (rd_in) data_out <= rdata;
  end

  assign irq_out = irq_en_q && (!empty || (ovf_q != '0));

endmodule

// File: tb/tb_ptp_ts_collector.sv
// Directed bench for ptp_ts_collector (4 channels, 4-deep FIFO) with a read-data scoreboard.
module tb_ptp_ts_collector;

`ifdef PTP_TS_COLLECTOR_DROP_CNT_EN
  localparam int DROP_ON = 1;
`else
  localparam int DROP_ON = 0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         wr_in = 1'b0;
  logic         rd_in = 1'b0;
  logic [7:0]   addr_in = '0;
  logic [31:0]  data_in = '0;
  logic [31:0]  data_out;
  logic [3:0]   ts_valid = '0;
  logic [3:0]   ts_ready;
  logic [319:0] ts_data = '0;
  logic [15:0]  ts_msgid = '0;
  logic         irq_out;

  ptp_ts_collector #(.NUM_CH(4), .DEPTH_LOG2(2), .ADDR_IS_IN_WORD(0)) dut (
    .clk(clk), .rst(rst), .wr_in(wr_in), .rd_in(rd_in), .addr_in(addr_in),
    .data_in(data_in), .data_out(data_out), .ts_valid(ts_valid), .ts_ready(ts_ready),
    .ts_data(ts_data), .ts_msgid(ts_msgid), .irq_out(irq_out)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  string       nm_q[$];
  logic        rd_d = 1'b0;
  logic [31:0] m_exp;
  string       m_nm;

  always @(posedge clk) rd_d <= rd_in;

  // Read-data monitor: every read strobe produces one scoreboard comparison.
  always @(negedge clk) begin
    if (rd_d) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_read got=%h", data_out);
      end else begin
        m_exp = exp_q.pop_front();
        m_nm  = nm_q.pop_front();
        if (data_out !== m_exp) begin
          errors++;
          $display("FAIL %s got=%h want=%h", m_nm, data_out, m_exp);
        end
      end
    end
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", n, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_wr(input logic [7:0] a, input logic [31:0] d);
    addr_in = a; data_in = d; wr_in = 1'b1;
    tick();
    wr_in = 1'b0;
  endtask

  task automatic reg_rd(input logic [7:0] a, input logic [31:0] exp, input string n);
    addr_in = a; rd_in = 1'b1;
    exp_q.push_back(exp);
    nm_q.push_back(n);
    tick();
    rd_in = 1'b0;
  endtask

  task automatic set_ch(input int c, input logic [47:0] sec, input logic [31:0] ns, input logic [3:0] msg);
    ts_data[80*c +: 80] = {sec, ns};
    ts_msgid[4*c +: 4]  = msg;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    tick(); tick();
    chk("rst_data_out", data_out, 32'h0);
    chk("rst_ts_ready", 32'(ts_ready), 32'h0);
    chk("rst_irq", 32'(irq_out), 32'h0);
    rst = 1'b0;
    reg_rd(8'h00, 32'h0, "rst_ctrl");
    reg_rd(8'h04, 32'h200, "rst_stat");

    // Single record on ch2; ch0 valid but disabled must be held.
    reg_wr(8'h00, 32'h4);
    set_ch(2, 48'h1, 32'h3B9AC9FF, 4'd3);
    ts_valid = 4'b0101;
    #1 chk("t1_ready", 32'(ts_ready), 32'h4);
    tick();
    ts_valid = 4'b0001;
    #1 chk("t1_ch0_held", 32'(ts_ready), 32'h0);
    reg_rd(8'h04, 32'h1, "t1_stat");
    reg_rd(8'h08, 32'h3B9AC9FF, "t1_ns");
    reg_rd(8'h0C, 32'h1, "t1_sec_lo");
    reg_rd(8'h10, 32'h0023_0000, "t1_sec_hi");
    reg_wr(8'h14, 32'h0);
    reg_rd(8'h04, 32'h200, "t1_stat_empty");
    reg_rd(8'h08, 32'h0, "t1_ns_empty");
    ts_valid = 4'b0000;

    // All channels valid from rr_ptr=0: grants 0,1,2,3,0 (last one dropped).
    rst = 1'b1; tick(); rst = 1'b0;
    reg_wr(8'h00, 32'hF);
    for (int c = 0; c < 4; c++) set_ch(c, 48'h100 + 48'(c), 32'h1000 + 32'(c), 4'(c));
    ts_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      #1 chk($sformatf("t2_grant%0d", k), 32'(ts_ready), 32'h1 << (k % 4));
      tick();
    end
    ts_valid = 4'h0;
    reg_rd(8'h04, 32'h0001_0404, "t2_stat");
    reg_rd(8'h08, 32'h1000, "t2_ns0");
    reg_rd(8'h10, 32'h0000_0000, "t2_hi0");
    reg_wr(8'h14, 32'h0);
    reg_rd(8'h10, 32'h0011_0000, "t2_hi1");
    reg_wr(8'h14, 32'h0);
    reg_rd(8'h10, 32'h0022_0000, "t2_hi2");
    reg_wr(8'h14, 32'h0);
    reg_rd(8'h10, 32'h0033_0000, "t2_hi3");
    reg_wr(8'h14, 32'h0);
    reg_rd(8'h04, 32'h0001_0200, "t2_stat_empty");
    reg_wr(8'h04, 32'h0001_0000);
    reg_rd(8'h04, 32'h200, "t2_stat_w1c");
    reg_rd(8'h18, (DROP_ON != 0) ? 32'd1 : 32'd0, "t2_drop");
    reg_rd(8'h18, 32'd0, "t2_drop_cleared");

    // Fill 4 on ch1 then 3 more dropped.
    reg_wr(8'h00, 32'h2);
    for (int k = 0; k < 7; k++) begin
      set_ch(1, 48'h55, 32'h2000 + 32'(k), 4'h9);
      ts_valid = 4'b0010;
      tick();
    end
    ts_valid = 4'b0000;
    reg_rd(8'h04, 32'h0002_0404, "t3_stat");
    reg_rd(8'h18, (DROP_ON != 0) ? 32'd3 : 32'd0, "t3_drop");
    reg_rd(8'h08, 32'h2000, "t3_ns");
    reg_rd(8'h10, 32'h0019_0000, "t3_hi");
    reg_wr(8'h04, 32'h0002_0000);
    reg_rd(8'h04, 32'h0404, "t3_stat_w1c");

    // Full FIFO: pop and ch0 push in the same cycle.
    reg_wr(8'h00, 32'h3);
    set_ch(0, 48'h7, 32'h3000, 4'd5);
    ts_valid = 4'b0001;
    addr_in = 8'h14; data_in = 32'h0; wr_in = 1'b1;
    #1 chk("t4_ready", 32'(ts_ready), 32'h1);
    tick();
    wr_in = 1'b0;
    ts_valid = 4'b0000;
    reg_rd(8'h04, 32'h0404, "t4_stat");
    reg_rd(8'h18, 32'd0, "t4_drop");
    reg_rd(8'h08, 32'h2001, "t4_ns1");
    reg_wr(8'h14, 32'h0);
    reg_rd(8'h08, 32'h2002, "t4_ns2");
    reg_wr(8'h14, 32'h0);
    reg_rd(8'h08, 32'h2003, "t4_ns3");
    reg_wr(8'h14, 32'h0);
    reg_rd(8'h08, 32'h3000, "t4_ns_tail");
    reg_rd(8'h10, 32'h0005_0000, "t4_hi_tail");
    reg_rd(8'h0C, 32'h7, "t4_lo_tail");
    reg_wr(8'h14, 32'h0);
    reg_rd(8'h04, 32'h200, "t4_stat_empty");

    // Flush with 3 records and a ch3 grant in the same cycle.
    reg_wr(8'h00, 32'hA);
    for (int k = 0; k < 3; k++) begin
      set_ch(1, 48'h66, 32'h4000 + 32'(k), 4'd1);
      ts_valid = 4'b0010;
      tick();
    end
    ts_valid = 4'b0000;
    reg_rd(8'h04, 32'h3, "t5_stat_pre");
    set_ch(3, 48'h9, 32'h5000, 4'd2);
    ts_valid = 4'b1000;
    addr_in = 8'h00; data_in = 32'h8000_000A; wr_in = 1'b1;
    #1 chk("t5_ready", 32'(ts_ready), 32'h8);
    tick();
    wr_in = 1'b0;
    ts_valid = 4'b0000;
    reg_rd(8'h04, 32'h200, "t5_stat");
    reg_rd(8'h18, 32'd0, "t5_drop");
    reg_rd(8'h08, 32'h0, "t5_ns");
    reg_rd(8'h00, 32'hA, "t5_ctrl");

    // Interrupt, then reset in the middle of a fill.
    reg_wr(8'h00, 32'h0001_0002);
    chk("t6_irq_idle", 32'(irq_out), 32'h0);
    set_ch(1, 48'h1, 32'h6000, 4'd1);
    ts_valid = 4'b0010;
    #1 chk("t6_irq_same", 32'(irq_out), 32'h0);
    tick();
    ts_valid = 4'b0000;
    chk("t6_irq_rise", 32'(irq_out), 32'h1);
    reg_wr(8'h14, 32'h0);
    chk("t6_irq_fall", 32'(irq_out), 32'h0);
    ts_valid = 4'b0010;
    tick(); tick();
    reg_rd(8'h04, 32'h2, "t6_stat_fill");
    rst = 1'b1;
    tick();
    chk("t6_rst_ready", 32'(ts_ready), 32'h0);
    chk("t6_rst_irq", 32'(irq_out), 32'h0);
    chk("t6_rst_data", data_out, 32'h0);
    rst = 1'b0;
    #1 chk("t6_held_ready", 32'(ts_ready), 32'h0);
    reg_rd(8'h04, 32'h200, "t6_stat_rst");
    reg_wr(8'h00, 32'h2);
    #1 chk("t6_rearb_ready", 32'(ts_ready), 32'h2);
    ts_valid = 4'b0000;

    tick(); tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d want=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
